// File: rtl/draw_scheduler_pkg.sv
// Shared defines for the draw scheduler: engine layer codes, FSM state encodings
// and the navigation location codes the scheduler forwards to the draw engine.
package draw_scheduler_pkg;

   typedef enum logic [1:0] {
      LAYER_BG   = 2'd0,
      LAYER_SPR  = 2'd1,
      LAYER_STAT = 2'd2,
      LAYER_RSVD = 2'd3
   } layer_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [3:0] LOC_HOME   = 4'd0;
   localparam logic [3:0] LOC_STREET = 4'd1;
   localparam logic [3:0] LOC_SHOP   = 4'd2;
   localparam logic [3:0] LOC_PARK   = 4'd3;

   localparam int unsigned WAIT_CW = 20;

   // Fixed priority: background, then sprite, then stats bar.
   function automatic layer_t pick_layer(input logic bg, input logic spr);
      layer_t sel;
      if (bg)
         sel = LAYER_BG;
      else if (spr)
         sel = LAYER_SPR;
      else
         sel = LAYER_STAT;
      return sel;
   endfunction

endpackage

// File: rtl/draw_scheduler_tick_divider.sv
// Frame-tick divider: counts tick pulses and emits a one-cycle wrap on every MOD-th tick.
// A clear returns the count to zero and suppresses any wrap in that cycle.
module tick_divider
   import draw_scheduler_pkg::*;
#(
   parameter int unsigned MOD = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic tick,
   output logic wrap
);

   localparam int unsigned CW = (MOD > 1) ? $clog2(MOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(MOD - 1);

   logic [CW-1:0] cnt;

   assign wrap = tick && !clr && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (tick)
         cnt <= wrap ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/draw_scheduler.sv
// Draw scheduler: turns navigation changes and frame-rate dividers into one-at-a-time
// draw-engine jobs (background > sprite > stats) with a watchdog on each job.
//
// state | meaning
// IDLE  | no job outstanding; launch when a layer is pending and the engine is ready
// ISSUE | one-cycle eng_start; clears the selected pending flag
// WAIT  | job running; leave on eng_done or when the watchdog expires
module draw_scheduler
   import draw_scheduler_pkg::*;
#(
   parameter int unsigned SPRITE_DIV = 8,
   parameter int unsigned STAT_DIV   = 60,
   parameter int unsigned TIMEOUT    = 1048575
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       transition,
   input  logic [3:0] location,
   input  logic [3:0] activity,
   input  logic       frame_tick,
   input  logic       eng_ready,
   input  logic       eng_done,
   output logic       eng_start,
   output logic [1:0] eng_layer,
   output logic [3:0] eng_location,
   output logic [3:0] eng_activity,
   output logic [1:0] eng_frame,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic [WAIT_CW-1:0] TO_LAST = 20'(TIMEOUT - 1);

   state_t              state;
   state_t              state_nxt;
   layer_t              layer_q;
   layer_t              sel_layer;
   logic                bg_pend;
   logic                spr_pend;
   logic                stat_pend;
   logic                spr_wrap;
   logic                stat_wrap;
   logic                launch;
   logic                job_done;
   logic                job_abort;
   logic                clr_bg;
   logic                clr_spr;
   logic                clr_stat;
   logic [WAIT_CW-1:0]  wait_cnt;

   tick_divider #(.MOD(SPRITE_DIV)) u_spr_div (
      .clk   (clk),
      .reset (reset),
      .clr   (transition),
      .tick  (frame_tick),
      .wrap  (spr_wrap)
   );

   tick_divider #(.MOD(STAT_DIV)) u_stat_div (
      .clk   (clk),
      .reset (reset),
      .clr   (transition),
      .tick  (frame_tick),
      .wrap  (stat_wrap)
   );

   assign sel_layer = pick_layer(bg_pend, spr_pend);

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      eng_start = 1'b0;
      busy      = 1'b0;
      launch    = 1'b0;
      job_done  = 1'b0;
      job_abort = 1'b0;
      case (state)
         ST_IDLE: begin
            if ((bg_pend || spr_pend || stat_pend) && eng_ready) begin
               launch    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            eng_start = 1'b1;
            busy      = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (eng_done) begin
               job_done  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (wait_cnt >= TO_LAST) begin
               job_abort = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign clr_bg   = (state == ST_ISSUE) && (layer_q == LAYER_BG);
   assign clr_spr  = (state == ST_ISSUE) && (layer_q == LAYER_SPR);
   assign clr_stat = (state == ST_ISSUE) && (layer_q == LAYER_STAT);

   // A set in the same cycle as the issue-time clear wins, so no request is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         bg_pend   <= 1'b1;
         spr_pend  <= 1'b0;
         stat_pend <= 1'b0;
      end else begin
         bg_pend   <= transition | (bg_pend & ~clr_bg);
         spr_pend  <= transition | spr_wrap | (spr_pend & ~clr_spr);
         stat_pend <= stat_wrap | (stat_pend & ~clr_stat);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         layer_q      <= LAYER_BG;
         eng_location <= 4'd0;
         eng_activity <= 4'd0;
      end else if (launch) begin
         layer_q      <= sel_layer;
         eng_location <= location;
         eng_activity <= activity;
      end
   end

   assign eng_layer = layer_q;

   always_ff @(posedge clk) begin
      if (reset)
         eng_frame <= 2'd0;
      else if (transition)
         eng_frame <= 2'd0;
      else if (job_done && (layer_q == LAYER_SPR))
         eng_frame <= eng_frame + 2'd1;
   end

   // Counts cycles since the ISSUE cycle; the abort edge lands TIMEOUT cycles after ISSUE.
   always_ff @(posedge clk) begin
      if (reset)
         wait_cnt <= '0;
      else if (state_nxt == ST_WAIT)
         wait_cnt <= (state == ST_ISSUE) ? 20'd1 : wait_cnt + 20'd1;
      else
         wait_cnt <= '0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         timeout_err <= 1'b0;
      else if (job_abort)
         timeout_err <= 1'b1;
   end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter: SPRITE_DIV, 8, frame_ticks between sprite redraw requests (range 1..255).
REQ-002 Parameter: STAT_DIV, 60, frame_ticks between stats-bar redraw requests (range 1..255).
REQ-003 Parameter: TIMEOUT, 1048575, max cycles in WAIT before abort (20-bit).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 transition  in  1  high for one cycle when the navigation state changes.
REQ-008 location  in  4  current location code from navigation.
REQ-009 activity  in  4  current activity code from navigation.
REQ-010 frame_tick  in  1  single-cycle pulse once per video frame.
REQ-011 eng_ready  in  1  draw engine idle and able to accept a start.
REQ-012 eng_done  in  1  single-cycle pulse when the engine finishes a job.
REQ-013 eng_start  out  1  single-cycle job launch pulse.
REQ-014 eng_layer  out  2  job layer: 0 background, 1 sprite, 2 stats; 3 unused.
REQ-015 eng_location, eng_activity  out  4 each  snapshot of location/activity taken at issue.
REQ-016 eng_frame  out  2  animation frame index for sprite jobs.
REQ-017 busy  out  1  high in ISSUE and WAIT.
REQ-018 timeout_err  out  1  sticky flag, set on a WAIT abort.

Function
REQ-019 Three pending flags: bg_pend, spr_pend, stat_pend.
REQ-020 transition sets bg_pend and spr_pend and clears both divider counters and eng_frame to 0 in the same cycle.
REQ-021 Sprite divider counts frame_ticks; on the SPRITE_DIV-th tick it sets spr_pend and returns to 0. The stats divider behaves the same with STAT_DIV and stat_pend.
REQ-022 FSM states: IDLE, ISSUE, WAIT.
REQ-023 IDLE -> ISSUE when any flag is pending and eng_ready=1. Otherwise the FSM stays in IDLE.
REQ-024 On the IDLE->ISSUE edge the block latches: the highest-priority pending layer (bg > sprite > stats), location, and activity into the eng_* outputs.
REQ-025 ISSUE lasts exactly one cycle: eng_start=1, the selected flag is cleared, next state WAIT. Start-to-request latency from IDLE is 1 cycle.
REQ-026 WAIT -> IDLE on eng_done=1. A sprite job also increments eng_frame modulo 4 (3 -> 0) on that edge.
REQ-027 WAIT -> IDLE when the wait counter reaches TIMEOUT without eng_done; timeout_err is set to 1 and eng_frame is unchanged.
REQ-028 If a flag's set event and clear event fall in the same cycle, set wins, so no request is lost.
REQ-029 eng_done outside WAIT is ignored.
REQ-030 A transition during WAIT does not abort the running job; bg is re-pended and issued after it.
REQ-031 eng_layer, eng_location, eng_activity and eng_frame hold their values between issues.
REQ-032 Divider counters and the wait counter do not overflow; widths are sized to their parameter.

Reset
REQ-033 Reset sets: state=IDLE, eng_start=0, busy=0, eng_layer=0, eng_location=0, eng_activity=0, eng_frame=0, timeout_err=0, all counters=0, spr_pend=0, stat_pend=0.
REQ-034 Reset sets bg_pend=1 so the first background is drawn after reset.
REQ-035 Reset asserted in ISSUE or WAIT abandons the job immediately; reset has priority over all other inputs.

Structure
REQ-036 Layer codes and FSM state encodings live in the shared project defines file, alongside the navigation location codes.
REQ-037 One sub-module, tick_divider (parameterised modulus, clear input, tick input, wrap pulse output), is instantiated twice.

Verification
REQ-038 Release reset with eng_ready=1 -> eng_start on cycle 2 with eng_layer=0 and eng_location=0; assert eng_done -> IDLE.
REQ-039 Pulse transition with location=1, activity=1 while IDLE -> background job (layer 0) first; after its eng_done, sprite job with layer 1, eng_location=1, eng_activity=1, eng_frame=0.
REQ-040 SPRITE_DIV=2, STAT_DIV=4, 4 frame_ticks, engine completes each job in 3 cycles -> issue order: sprite, then sprite and stats both pending -> sprite before stats; eng_frame steps 0, 1, 2.
REQ-041 Transition pulsed in the same cycle that ISSUE clears bg_pend -> a second background job is issued after the first job's eng_done.
REQ-042 TIMEOUT=16, eng_done withheld -> return to IDLE 16 cycles after ISSUE, timeout_err=1 and stays 1 until reset.
REQ-043 Reset asserted mid-WAIT -> next cycle busy=0, eng_start=0, bg_pend=1; a stray eng_done afterwards has no effect.
